// File: rtl/wr_gate_fifo.sv
// -----------------------------------------------------------------------------
// wr_gate_fifo
//
// Synchronous single-clock FIFO whose writes are qualified by an upstream
// write-permit (enable). Reads are registered with a one-cycle latency.
// Error conditions are reported as one-cycle pulses.
//
// Parameters:
//   WIDTH      data word width in bits
//   DEPTH      number of storage entries (power of two, >= 2)
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   enable     write-permit qualifier
//   write      write request
//   wdata      write data, sampled with write
//   read       read request
//   rdata      registered read data, holds when no pop occurs
//   rvalid     one-cycle strobe: rdata holds a newly popped word
//   full       count == DEPTH
//   empty      count == 0
//   count      current occupancy
//   wr_err     pulse: write seen while enable low
//   overflow   pulse: enabled write rejected because full
//   underflow  pulse: read rejected because empty
//   viol_cnt   (only with WR_GATE_VIOL_CNT_EN) saturating count of cycles
//              with write & !enable
//
// Optional feature macro: WR_GATE_VIOL_CNT_EN
// -----------------------------------------------------------------------------
module wr_gate_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     write,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     read,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wr_err,
  output logic                     overflow,
  output logic                     underflow
`ifdef WR_GATE_VIOL_CNT_EN
  ,
  output logic [7:0]               viol_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] rdata_r;
  logic             rvalid_r;
  logic             wr_err_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  // Status flags decode from the registered occupancy only.
  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == {CW{1'b0}});

  // Full is judged before any same-cycle pop, so a write at full is always
  // rejected even when a read frees a slot in the same cycle.
  assign push_s = write & enable & ~full_s;
  assign pop_s  = read & ~empty_s;

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered read port: rdata holds its value unless a pop occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r  <= {WIDTH{1'b0}};
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= pop_s;
      if (pop_s) begin
        rdata_r <= mem_r[rd_ptr_r];
      end
    end
  end

  // Error pulses, one per offending cycle; suppressed in reset cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_err_r    <= write & ~enable;
      overflow_r  <= write & enable & full_s;
      underflow_r <= read & empty_s;
    end
  end

`ifdef WR_GATE_VIOL_CNT_EN
  logic [7:0] viol_cnt_r;

  // Saturating count of cycles carrying a write without permit.
  always_ff @(posedge clk) begin
    if (rst) begin
      viol_cnt_r <= 8'd0;
    end else if (write && !enable && (viol_cnt_r != 8'hFF)) begin
      viol_cnt_r <= viol_cnt_r + 8'd1;
    end else begin
      viol_cnt_r <= viol_cnt_r;
    end
  end

  assign viol_cnt = viol_cnt_r;
`endif

  assign rdata     = rdata_r;
  assign rvalid    = rvalid_r;
  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_r;
  assign wr_err    = wr_err_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_wr_gate_fifo.sv
// -----------------------------------------------------------------------------
// tb_wr_gate_fifo
//
// Directed bench for wr_gate_fifo (WIDTH=8, DEPTH=16). Stimulus pushes the
// expected read word into a scoreboard queue; a negedge monitor pops and
// compares whenever rvalid is seen. Per-cycle status/flag checks use a small
// occupancy model kept by the bench.
// -----------------------------------------------------------------------------
module tb_wr_gate_fifo;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         write;
  logic [W-1:0] wdata;
  logic         read;
  logic [W-1:0] rdata;
  logic         rvalid;
  logic         full;
  logic         empty;
  logic [4:0]   count;
  logic         wr_err;
  logic         overflow;
  logic         underflow;
`ifdef WR_GATE_VIOL_CNT_EN
  logic [7:0]   viol_cnt;
  int           exp_viol = 0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rd = 8'h00;

  always #5 clk = ~clk;

  wr_gate_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .write     (write),
    .wdata     (wdata),
    .read      (read),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .wr_err    (wr_err),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef WR_GATE_VIOL_CNT_EN
    ,
    .viol_cnt  (viol_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        chk("rdata_order", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // One clock of stimulus; the bench model predicts the post-edge state.
  task automatic cyc(input logic w, input logic e, input logic [W-1:0] d, input logic r);
    int sz;
    logic ep, eq, ewr, eov, eun;
    sz  = model_q.size();
    ep  = w & e & (sz < D);
    eq  = r & (sz > 0);
    ewr = w & ~e;
    eov = w & e & (sz == D);
    eun = r & (sz == 0);
    if (eq) begin
      last_rd = model_q.pop_front();
      exp_q.push_back(last_rd);
    end
    if (ep) model_q.push_back(d);
`ifdef WR_GATE_VIOL_CNT_EN
    if (ewr && exp_viol < 255) exp_viol++;
`endif
    write  = w;
    enable = e;
    wdata  = d;
    read   = r;
    @(posedge clk);
    #1;
    chk("count",     {27'd0, count},     32'(model_q.size()));
    chk("full",      {31'd0, full},      {31'd0, (model_q.size() == D)});
    chk("empty",     {31'd0, empty},     {31'd0, (model_q.size() == 0)});
    chk("wr_err",    {31'd0, wr_err},    {31'd0, ewr});
    chk("overflow",  {31'd0, overflow},  {31'd0, eov});
    chk("underflow", {31'd0, underflow}, {31'd0, eun});
    chk("rvalid",    {31'd0, rvalid},    {31'd0, eq});
    chk("rdata_hold",{24'd0, rdata},     {24'd0, last_rd});
`ifdef WR_GATE_VIOL_CNT_EN
    chk("viol_cnt",  {24'd0, viol_cnt},  32'(exp_viol));
`endif
  endtask

  // One reset cycle with arbitrary requests applied; everything must clear.
  task automatic do_reset(input logic w, input logic r);
    rst    = 1'b1;
    write  = w;
    enable = 1'b1;
    wdata  = 8'hEE;
    read   = r;
    model_q.delete();
    last_rd = 8'h00;
`ifdef WR_GATE_VIOL_CNT_EN
    exp_viol = 0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count",     {27'd0, count},     32'd0);
    chk("rst_empty",     {31'd0, empty},     32'd1);
    chk("rst_full",      {31'd0, full},      32'd0);
    chk("rst_rvalid",    {31'd0, rvalid},    32'd0);
    chk("rst_rdata",     {24'd0, rdata},     32'd0);
    chk("rst_wr_err",    {31'd0, wr_err},    32'd0);
    chk("rst_overflow",  {31'd0, overflow},  32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
`ifdef WR_GATE_VIOL_CNT_EN
    chk("rst_viol_cnt",  {24'd0, viol_cnt},  32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; write = 1'b0; wdata = 8'h00; read = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);

    // Basic ordering: three writes then three reads.
    cyc(1'b1, 1'b1, 8'hA1, 1'b0);
    cyc(1'b1, 1'b1, 8'hB2, 1'b0);
    cyc(1'b1, 1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);

    // Writes without permit: no storage change, wr_err pulses.
    cyc(1'b1, 1'b0, 8'h55, 1'b0);
    cyc(1'b1, 1'b0, 8'h55, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);

    // Fill to full, overflow, then write+read at full.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
    cyc(1'b1, 1'b1, 8'hF0, 1'b0);
    cyc(1'b1, 1'b1, 8'hF1, 1'b1);
    // Gated write at full must not disturb anything either.
    cyc(1'b1, 1'b0, 8'hF2, 1'b0);

    // Drain to 5, then 20 cycles of simultaneous push/pop across wrap.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 8'(8'h80 + i), 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1);

    // Read while empty: underflow, no rvalid, rdata held.
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset mid-operation with requests active discards contents.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    do_reset(1'b1, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);

    // Every scoreboard entry must have been consumed by the monitor.
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
